// File: rtl/product_accumulator_pkg.sv
// Shared types for the product accumulator: FSM state encoding, default widths
// and a small helper that decides input-side readiness from the FSM state.
// No logic of its own; imported by the interface and the top level.
package product_accumulator_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_ACC_WIDTH = 24;
  localparam int DEF_CNT_WIDTH = 8;

  // Encodings are fixed so other PE stages can decode the same state values
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Input side is open in every state except while a result is being presented
  function automatic logic accepts_input(input state_t s);
    return (s != ST_DONE);
  endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Purpose: product stream in (valid/ready + last tag), reduction result out (valid/ready).
// Latency: none, signal bundle only.
// Backpressure: in_rdy from the accumulator, out_rdy from the consumer.
interface product_accumulator_if
  import product_accumulator_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
);

  logic                   in_vld;
  logic                   in_rdy;
  logic [2*WIDTH-1:0]     in_dat;
  logic                   in_last;
  logic                   out_vld;
  logic                   out_rdy;
  logic [ACC_WIDTH-1:0]   out_acc;
  logic [CNT_WIDTH-1:0]   out_cnt;
  logic                   out_ovf;

  // Producer of products and consumer of results
  modport master (
    output in_vld, in_dat, in_last, out_rdy,
    input  in_rdy, out_vld, out_acc, out_cnt, out_ovf
  );

  // The accumulator itself
  modport slave (
    input  in_vld, in_dat, in_last, out_rdy,
    output in_rdy, out_vld, out_acc, out_cnt, out_ovf
  );

endinterface

// File: rtl/product_accumulator_acc_adder.sv
// Purpose: ACC_WIDTH unsigned adder reporting carry-out as overflow; clamps under ACC_SATURATE_EN.
// Latency: combinational.
// Backpressure: none.
module product_accumulator_acc_adder #(
  parameter int ACC_WIDTH = 24
) (
  input  logic [ACC_WIDTH-1:0] i_a,
  input  logic [ACC_WIDTH-1:0] i_b,
  output logic [ACC_WIDTH-1:0] o_sum,
  output logic                 o_ovf
);

  logic [ACC_WIDTH:0] w_full;

  // One extra bit captures the carry out of the top accumulator bit
  always_comb begin
    w_full = {1'b0, i_a} + {1'b0, i_b};
    o_ovf  = w_full[ACC_WIDTH];
`ifdef ACC_SATURATE_EN
    // Once clamped, any further non-zero term carries again, so the value stays at all-ones
    o_sum  = w_full[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : w_full[ACC_WIDTH-1:0];
`else
    o_sum  = w_full[ACC_WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/product_accumulator.sv
// Purpose: sums a stream of 2*WIDTH-bit products into ACC_WIDTH bits, presents total on LAST (ACC_SATURATE_EN selects clamp vs wrap).
// Latency: result valid the cycle after the LAST beat is accepted; one bubble per reduction.
// Backpressure: in_rdy is registered from state only (low while DONE); result held until out_rdy.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  product_accumulator_if.slave  io_bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_in_rdy;
  logic                   r_out_vld;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_ovf;

  logic                   w_accept;
  logic                   w_load;
  logic                   w_add;
  logic                   w_clear;
  logic [2*WIDTH-1:0]     w_p;
  logic [ACC_WIDTH-1:0]   w_p_ext;
  logic [ACC_WIDTH-1:0]   w_sum;
  logic                   w_add_ovf;
  logic                   w_cnt_sat;

  assign w_p       = io_bus.in_dat;
  assign w_p_ext   = ACC_WIDTH'(w_p);
  assign w_cnt_sat = (r_cnt == CNT_MAX);

  product_accumulator_acc_adder #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_acc_adder (
    .i_a   (r_acc),
    .i_b   (w_p_ext),
    .o_sum (w_sum),
    .o_ovf (w_add_ovf)
  );

  // Next state and datapath strobes; the handshake uses the registered ready only
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = io_bus.in_vld && r_in_rdy;
    w_load      = 1'b0;
    w_add       = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_load      = 1'b1;
          w_state_nxt = io_bus.in_last ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (w_accept) begin
          w_add       = 1'b1;
          w_state_nxt = io_bus.in_last ? ST_DONE : ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (io_bus.out_rdy) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State plus both handshake flags registered from the next state, so neither port sees a comb path
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_in_rdy  <= 1'b0;
      r_out_vld <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_in_rdy  <= accepts_input(w_state_nxt);
      r_out_vld <= (w_state_nxt == ST_DONE);
    end
  end

  // Running sum, saturating term count and sticky overflow for the current reduction
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_load) begin
      r_acc <= w_p_ext;
      r_cnt <= CNT_WIDTH'(1);
      r_ovf <= 1'b0;
    end else if (w_add) begin
      r_acc <= w_sum;
      if (!w_cnt_sat) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
      r_ovf <= r_ovf | w_add_ovf | w_cnt_sat;
    end else if (w_clear) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end
  end

  assign io_bus.in_rdy  = r_in_rdy;
  assign io_bus.out_vld = r_out_vld;
  assign io_bus.out_acc = r_acc;
  assign io_bus.out_cnt = r_cnt;
  assign io_bus.out_ovf = r_ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three instances (24/8, 16/8, 24/2 acc/cnt widths) share one stimulus.
// Expected values are hand-computed; the random pass uses a plain running-sum model.
module tb_product_accumulator;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        tb_vld  = 1'b0;
  logic        tb_last = 1'b0;
  logic        tb_ordy = 1'b0;
  logic [15:0] tb_dat  = 16'd0;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  product_accumulator_if #(.WIDTH(8), .ACC_WIDTH(24), .CNT_WIDTH(8)) if0 ();
  product_accumulator_if #(.WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(8)) if1 ();
  product_accumulator_if #(.WIDTH(8), .ACC_WIDTH(24), .CNT_WIDTH(2)) if2 ();

  assign if0.in_vld = tb_vld;  assign if0.in_dat = tb_dat;  assign if0.in_last = tb_last;  assign if0.out_rdy = tb_ordy;
  assign if1.in_vld = tb_vld;  assign if1.in_dat = tb_dat;  assign if1.in_last = tb_last;  assign if1.out_rdy = tb_ordy;
  assign if2.in_vld = tb_vld;  assign if2.in_dat = tb_dat;  assign if2.in_last = tb_last;  assign if2.out_rdy = tb_ordy;

  product_accumulator #(.WIDTH(8), .ACC_WIDTH(24), .CNT_WIDTH(8)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .io_bus(if0.slave));
  product_accumulator #(.WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(8)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .io_bus(if1.slave));
  product_accumulator #(.WIDTH(8), .ACC_WIDTH(24), .CNT_WIDTH(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .io_bus(if2.slave));

  // Present one beat, wait (bounded) until it is taken, then drop valid
  task automatic send_beat(input logic [15:0] p, input logic last);
    int n;
    n = 0;
    tb_vld = 1'b1; tb_dat = p; tb_last = last;
    while (if0.in_rdy !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (n >= 100) begin
      n_fail++;
      $display("FAIL send_beat_timeout: in_rdy=%b required 1", if0.in_rdy);
    end
    @(posedge clk); #1;
    tb_vld = 1'b0; tb_last = 1'b0;
  endtask

  // Hand the result to the consumer for one cycle
  task automatic release_result;
    tb_ordy = 1'b1;
    @(posedge clk); #1;
    tb_ordy = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (if0.in_rdy  !== 1'b0)  begin n_fail++; $display("FAIL rst_in_rdy: got %b want 0", if0.in_rdy); end
    n_checks++; if (if0.out_vld !== 1'b0)  begin n_fail++; $display("FAIL rst_out_vld: got %b want 0", if0.out_vld); end
    n_checks++; if (if0.out_acc !== 24'd0) begin n_fail++; $display("FAIL rst_out_acc: got %h want 0", if0.out_acc); end
    n_checks++; if (if0.out_cnt !== 8'd0)  begin n_fail++; $display("FAIL rst_out_cnt: got %h want 0", if0.out_cnt); end
    n_checks++; if (if0.out_ovf !== 1'b0)  begin n_fail++; $display("FAIL rst_out_ovf: got %b want 0", if0.out_ovf); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    n_checks++; if (if0.in_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_rdy_before_edge: got %b want 0", if0.in_rdy); end
    @(posedge clk); #1;
    n_checks++; if (if0.in_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_rdy_after_edge: got %b want 1", if0.in_rdy); end
  endtask

  task automatic test_basic;
    tb_ordy = 1'b1;
    send_beat(16'd3, 1'b0);
    send_beat(16'd5, 1'b0);
    send_beat(16'd7, 1'b1);
    n_checks++; if (if0.out_vld !== 1'b1)  begin n_fail++; $display("FAIL basic_vld: got %b want 1", if0.out_vld); end
    n_checks++; if (if0.out_acc !== 24'd15) begin n_fail++; $display("FAIL basic_acc: got %0d want 15", if0.out_acc); end
    n_checks++; if (if0.out_cnt !== 8'd3)  begin n_fail++; $display("FAIL basic_cnt: got %0d want 3", if0.out_cnt); end
    n_checks++; if (if0.out_ovf !== 1'b0)  begin n_fail++; $display("FAIL basic_ovf: got %b want 0", if0.out_ovf); end
    n_checks++; if (if0.in_rdy  !== 1'b0)  begin n_fail++; $display("FAIL basic_rdy_done: got %b want 0", if0.in_rdy); end
    @(posedge clk); #1;
    n_checks++; if (if0.out_vld !== 1'b0)  begin n_fail++; $display("FAIL basic_vld_drop: got %b want 0", if0.out_vld); end
    n_checks++; if (if0.in_rdy  !== 1'b1)  begin n_fail++; $display("FAIL basic_rdy_idle: got %b want 1", if0.in_rdy); end
    tb_ordy = 1'b0;
  endtask

  task automatic test_single_hold;
    tb_ordy = 1'b0;
    send_beat(16'hFE01, 1'b1);
    n_checks++; if (if0.out_vld !== 1'b1 || if0.out_acc !== 24'h00FE01 || if0.out_cnt !== 8'd1)
      begin n_fail++; $display("FAIL single_result: vld=%b acc=%h cnt=%0d want 1/00fe01/1", if0.out_vld, if0.out_acc, if0.out_cnt); end
    // A new beat waits upstream while the result is held
    tb_vld = 1'b1; tb_dat = 16'd2; tb_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (if0.in_rdy !== 1'b0 || if0.out_vld !== 1'b1 || if0.out_acc !== 24'h00FE01 || if0.out_cnt !== 8'd1)
        begin n_fail++; $display("FAIL single_hold%0d: rdy=%b vld=%b acc=%h cnt=%0d want 0/1/00fe01/1", i, if0.in_rdy, if0.out_vld, if0.out_acc, if0.out_cnt); end
    end
    tb_ordy = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (if0.out_vld !== 1'b0 || if0.in_rdy !== 1'b1)
      begin n_fail++; $display("FAIL single_release: vld=%b rdy=%b want 0/1", if0.out_vld, if0.in_rdy); end
    @(posedge clk); #1;
    tb_vld = 1'b0; tb_last = 1'b0;
    n_checks++; if (if0.out_vld !== 1'b1 || if0.out_acc !== 24'd2 || if0.out_cnt !== 8'd1)
      begin n_fail++; $display("FAIL single_next_from_zero: vld=%b acc=%h cnt=%0d want 1/2/1", if0.out_vld, if0.out_acc, if0.out_cnt); end
    @(posedge clk); #1;
    tb_ordy = 1'b0;
  endtask

  task automatic test_acc_overflow;
    logic [15:0] exp16;
`ifdef ACC_SATURATE_EN
    exp16 = 16'hFFFF;
`else
    exp16 = 16'h0001;
`endif
    send_beat(16'hFE01, 1'b0);
    send_beat(16'h0200, 1'b1);
    n_checks++; if (if1.out_acc !== exp16) begin n_fail++; $display("FAIL ovf16_acc: got %h want %h", if1.out_acc, exp16); end
    n_checks++; if (if1.out_ovf !== 1'b1)  begin n_fail++; $display("FAIL ovf16_flag: got %b want 1", if1.out_ovf); end
    n_checks++; if (if0.out_acc !== 24'h010001 || if0.out_ovf !== 1'b0)
      begin n_fail++; $display("FAIL ovf24_wide: acc=%h ovf=%b want 010001/0", if0.out_acc, if0.out_ovf); end
    release_result();
  endtask

  task automatic test_cnt_sat;
    for (int i = 0; i < 5; i++) send_beat(16'd1, (i == 4));
    n_checks++; if (if2.out_cnt !== 2'd3)   begin n_fail++; $display("FAIL cntsat_cnt: got %0d want 3", if2.out_cnt); end
    n_checks++; if (if2.out_ovf !== 1'b1)   begin n_fail++; $display("FAIL cntsat_ovf: got %b want 1", if2.out_ovf); end
    n_checks++; if (if2.out_acc !== 24'd5)  begin n_fail++; $display("FAIL cntsat_acc: got %0d want 5", if2.out_acc); end
    n_checks++; if (if0.out_cnt !== 8'd5 || if0.out_ovf !== 1'b0)
      begin n_fail++; $display("FAIL cnt8_wide: cnt=%0d ovf=%b want 5/0", if0.out_cnt, if0.out_ovf); end
    release_result();
  endtask

  task automatic test_random;
    int nb, g;
    longint sum;
    logic [15:0] v, e16;
    logic [23:0] hold;
    logic e16_ovf;
    for (int r = 0; r < 1000; r++) begin
      nb  = int'($urandom_range(1, 6));
      sum = 0;
      for (int b = 0; b < nb; b++) begin
        g = int'($urandom_range(0, 2));
        repeat (g) begin @(posedge clk); #1; end
        v = 16'($urandom_range(0, 65535) >> $urandom_range(0, 4));
        sum = sum + longint'(v);
        send_beat(v, (b == nb - 1));
      end
      e16_ovf = (sum > 64'd65535);
`ifdef ACC_SATURATE_EN
      e16 = e16_ovf ? 16'hFFFF : sum[15:0];
`else
      e16 = sum[15:0];
`endif
      n_checks++;
      if (if0.out_vld !== 1'b1 || if0.out_acc !== sum[23:0] || if0.out_cnt !== 8'(nb) || if0.out_ovf !== 1'b0)
        begin n_fail++; $display("FAIL rnd%0d_d0: vld=%b acc=%h cnt=%0d ovf=%b want 1/%h/%0d/0", r, if0.out_vld, if0.out_acc, if0.out_cnt, if0.out_ovf, sum[23:0], nb); end
      n_checks++;
      if (if1.out_acc !== e16 || if1.out_ovf !== e16_ovf)
        begin n_fail++; $display("FAIL rnd%0d_d1: acc=%h ovf=%b want %h/%b", r, if1.out_acc, if1.out_ovf, e16, e16_ovf); end
      n_checks++;
      if (if2.out_acc !== sum[23:0] || if2.out_cnt !== 2'((nb > 3) ? 3 : nb) || if2.out_ovf !== (nb > 3))
        begin n_fail++; $display("FAIL rnd%0d_d2: acc=%h cnt=%0d ovf=%b want %h/%0d/%b", r, if2.out_acc, if2.out_cnt, if2.out_ovf, sum[23:0], (nb > 3) ? 3 : nb, (nb > 3)); end
      hold = sum[23:0];
      g = int'($urandom_range(0, 3));
      repeat (g) begin @(posedge clk); #1; end
      n_checks++;
      if (if0.out_vld !== 1'b1 || if0.out_acc !== hold)
        begin n_fail++; $display("FAIL rnd%0d_hold: vld=%b acc=%h want 1/%h", r, if0.out_vld, if0.out_acc, hold); end
      release_result();
    end
  endtask

  task automatic test_reset_mid;
    send_beat(16'd4, 1'b0);
    send_beat(16'd6, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (if0.out_vld !== 1'b0 || if0.out_acc !== 24'd0 || if0.out_cnt !== 8'd0 || if0.in_rdy !== 1'b0)
      begin n_fail++; $display("FAIL rstmid_accum: vld=%b acc=%h cnt=%0d rdy=%b want 0/0/0/0", if0.out_vld, if0.out_acc, if0.out_cnt, if0.in_rdy); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send_beat(16'd8, 1'b1);
    n_checks++; if (if0.out_vld !== 1'b1) begin n_fail++; $display("FAIL rstmid_done_pre: vld=%b want 1", if0.out_vld); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (if0.out_vld !== 1'b0 || if0.out_acc !== 24'd0)
      begin n_fail++; $display("FAIL rstmid_done: vld=%b acc=%h want 0/0", if0.out_vld, if0.out_acc); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send_beat(16'd9, 1'b0);
    send_beat(16'd1, 1'b1);
    n_checks++; if (if0.out_vld !== 1'b1 || if0.out_acc !== 24'd10 || if0.out_cnt !== 8'd2 || if0.out_ovf !== 1'b0)
      begin n_fail++; $display("FAIL rstmid_next: vld=%b acc=%0d cnt=%0d ovf=%b want 1/10/2/0", if0.out_vld, if0.out_acc, if0.out_cnt, if0.out_ovf); end
    release_result();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_hold();
    test_acc_overflow();
    test_cnt_sat();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
